// File: rtl/mips_cpu_reg_writeback.sv
// Write-back queue in front of the register file write port.
// Collects writes from the ALU path (A, fixed priority) and the load-return
// path (B) into an in-order FIFO, then drains one entry per cycle.
// Optional bypass lookup is built only when WB_BYPASS_EN is defined.
module mips_cpu_reg_writeback #(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       a_valid,
  output logic                       a_ready,
  input  logic [4:0]                 a_addr,
  input  logic [DATA_W-1:0]          a_data,
  input  logic                       b_valid,
  output logic                       b_ready,
  input  logic [4:0]                 b_addr,
  input  logic [DATA_W-1:0]          b_data,
  input  logic                       hold,
  output logic                       write,
  output logic [4:0]                 wrAddr,
  output logic [DATA_W-1:0]          wrData,
  input  logic [4:0]                 lk_addr,
  output logic                       lk_hit,
  output logic [DATA_W-1:0]          lk_data,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       full,
  output logic                       empty
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic [4:0]        addr_q [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [PW-1:0]     head_q, tail_q;
  logic [CW-1:0]     count_q;

  logic              pop, push, a_fire, b_fire;
  logic [4:0]        push_addr;
  logic [DATA_W-1:0] push_data;

  assign empty   = (count_q == '0);
  assign full    = (count_q == CW'(DEPTH));
  assign count   = count_q;

  // The register file always accepts, so a visible write is a completed pop.
  assign pop     = !empty && !hold;
  assign a_ready = !full || pop;
  assign b_ready = !a_valid && (!full || pop);
  assign a_fire  = a_valid && a_ready;
  assign b_fire  = b_valid && b_ready;

  assign push_addr = a_fire ? a_addr : b_addr;
  assign push_data = a_fire ? a_data : b_data;
  // Writes to r0 complete the handshake but are dropped.
  assign push      = (a_fire || b_fire) && (push_addr != 5'd0);

  assign write  = pop;
  assign wrAddr = pop ? addr_q[head_q] : 5'd0;
  assign wrData = pop ? data_q[head_q] : '0;

  // Entry storage; not reset since stale entries are masked by count.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail_q] <= push_addr;
      data_q[tail_q] <= push_data;
    end
  end

  // Pointers and occupancy; pointers wrap naturally as DEPTH is a power of two.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) tail_q <= tail_q + PW'(1);
      if (pop)  head_q <= head_q + PW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (pop && !push) count_q <= count_q - CW'(1);
    end
  end

`ifdef WB_BYPASS_EN
  logic [PW-1:0] lk_idx;

  // Scan from oldest to youngest so the youngest match wins.
  always_comb begin
    lk_hit  = 1'b0;
    lk_data = '0;
    lk_idx  = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PW'(i);
      if ((CW'(i) < count_q) && (addr_q[lk_idx] == lk_addr) && (lk_addr != 5'd0)) begin
        lk_hit  = 1'b1;
        lk_data = data_q[lk_idx];
      end
    end
  end
`else
  logic unused_lk_addr;
  assign unused_lk_addr = ^lk_addr;
  assign lk_hit  = 1'b0;
  assign lk_data = '0;
`endif

endmodule
